// File: rtl/keypad_emulator.sv
// Stands in for a 4x4 matrix keypad: answers the scanner's column drive on the
// row lines as if one key (one hex nibble, or two for a byte) were pressed.
module keypad_emulator #(
  parameter int PRESS_CYCLES   = 5000,
  parameter int RELEASE_CYCLES = 5000,
  parameter int BOUNCE_CYCLES  = 0,
  parameter int BOUNCE_TOGGLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] fil,
  input  logic [7:0] byte_in,
  input  logic       nibble_mode,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] key_active
);

  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    lo_q;
  logic          pending_q;
  logic [3:0]    key_q;
  logic          busy_q;
  logic          done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lo_q      <= 4'h0;
      pending_q <= 1'b0;
      key_q     <= 4'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= PRESS;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            lo_q      <= byte_in[3:0];
            pending_q <= ~nibble_mode;
            key_q     <= nibble_mode ? byte_in[3:0] : byte_in[7:4];
          end
        end
        PRESS: begin
          if (cnt_q == P_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == R_LAST) begin
            cnt_q <= '0;
            if (pending_q) begin
              state_q   <= PRESS;
              key_q     <= lo_q;
              pending_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Contact chatters in BOUNCE_TOGGLE-cycle slots at the start of each press.
  logic closed;
  always_comb begin
    closed = 1'b0;
    if (state_q == PRESS) begin
      if (int'(cnt_q) < BOUNCE_CYCLES)
        closed = ((int'(cnt_q) / BOUNCE_TOGGLE) % 2) == 0;
      else
        closed = 1'b1;
    end
  end

  // Physical key position {row, column} of each hex nibble.
  function automatic logic [3:0] key_pos(input logic [3:0] k);
    case (k)
      4'h1:    key_pos = 4'b00_00;
      4'h2:    key_pos = 4'b00_01;
      4'h3:    key_pos = 4'b00_10;
      4'hA:    key_pos = 4'b00_11;
      4'h4:    key_pos = 4'b01_00;
      4'h5:    key_pos = 4'b01_01;
      4'h6:    key_pos = 4'b01_10;
      4'hB:    key_pos = 4'b01_11;
      4'h7:    key_pos = 4'b10_00;
      4'h8:    key_pos = 4'b10_01;
      4'h9:    key_pos = 4'b10_10;
      4'hC:    key_pos = 4'b10_11;
      4'hE:    key_pos = 4'b11_00;
      4'hF:    key_pos = 4'b11_10;
      4'hD:    key_pos = 4'b11_11;
      default: key_pos = 4'b11_01;
    endcase
  endfunction

  logic [1:0] key_row;
  logic [1:0] key_col;
  logic       col_low;

  assign {key_row, key_col} = key_pos(key_q);
  assign col_low = ~col[2'd3 - key_col];

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign fil[3-gi] = ~(closed & col_low & (key_row == 2'(gi)));
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign key_active = key_q;

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable responder for the 4x4 matrix-keypad scan interface used by the divider top level. It watches the column lines driven by the keypad scanner and answers on the row lines exactly as a pressed physical key would. Presses include a timed hold, a release gap and optional contact bounce. It sits in place of the physical keypad for hardware self-test and bench stimulus, and types one hex nibble or a full byte (MSB nibble first) per request.

## Interface
Parameters:
- PRESS_CYCLES, 5000: clock cycles a key is held closed (≥1).
- RELEASE_CYCLES, 5000: clock cycles of open contact after each press (≥1).
- BOUNCE_CYCLES, 0: cycles at the start of each press during which the contact bounces. 0 disables bounce. Must be < PRESS_CYCLES.
- BOUNCE_TOGGLE, 16: contact toggle period during bounce (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- col  in  4  column drive from the scanner; a low bit is an active column. col[3]=column 0 … col[0]=column 3.
- fil  out  4  row sense to the scanner; low = key contact. fil[3]=row 0 … fil[0]=row 3.
- byte_in  in  8  value to type; sampled on accepted start.
- nibble_mode  in  1  1: type only byte_in[3:0]; 0: type byte_in[7:4] then byte_in[3:0]. Sampled with start.
- start  in  1  request; accepted only in IDLE.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse when the last release gap ends.
- key_active  out  4  nibble currently being typed (held through its release gap).

## Operation
- Key map (row, column):
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: E, 0, F, D
- Key for nibble k is at (r, c). Contact is modelled as a switch from column c to row r:
  - fil[3-r] = ~(closed & ~col[3-c]).
  - All other fil bits are 1.
  - fil is combinational from col and registered state (no clock delay from col to fil).
  - If several columns are low at once, the row goes low whenever the key's column is low.
- closed = 1 only in PRESS, with bounce applied as follows:
  - Let cnt be the PRESS cycle index, 0-based.
  - If cnt < BOUNCE_CYCLES: closed = ((cnt / BOUNCE_TOGGLE) mod 2 == 0).
  - Otherwise closed = 1.
- FSM states: IDLE, PRESS, RELEASE.
  - IDLE→PRESS on start. Latch byte_in and nibble_mode. key_active = first nibble (byte_in[7:4], or byte_in[3:0] in nibble mode). Clear cnt.
  - PRESS→RELEASE after PRESS_CYCLES cycles. Clear cnt.
  - RELEASE→PRESS after RELEASE_CYCLES cycles if a second nibble is pending. key_active = byte_in[3:0].
  - RELEASE→IDLE after RELEASE_CYCLES cycles if no nibble is pending. Pulse done.
- start while busy is ignored; latched data is unchanged.
- Counter width is $clog2(max(PRESS_CYCLES, RELEASE_CYCLES)+1). It saturates nowhere and is always cleared on state change.
- Reset (asynchronous, any state): state=IDLE, fil=4'b1111 immediately, busy=0, done=0, key_active=0, cnt=0, pending nibble cleared.

## Timing
- Cycle 0 = the clock edge where start is sampled high in IDLE.
- Nibble mode:
  - PRESS covers cycles 1..P.
  - RELEASE covers cycles P+1..P+R.
  - done=1 and busy=0 in cycle P+R+1.
- Byte mode:
  - Second PRESS covers cycles P+R+1..2P+R.
  - Second RELEASE covers cycles 2P+R+1..2(P+R).
  - done=1 and busy=0 in cycle 2(P+R)+1.
- busy is high exactly in the PRESS/RELEASE cycles. done never coincides with busy.
- A new start is accepted in the same cycle done is high (state is IDLE).
- fil reacts to col within the same cycle (zero-cycle combinational path).

## Test plan
- Reset: hold rst=0 with col toggling → fil=1111, busy=0, done=0, key_active=0. Assert rst=0 mid-PRESS → fil=1111 before the next clk edge, then IDLE.
- Nibble 5, P=8, R=4, nibble_mode=1:
  - Cycles 1–8: col=1011 → fil=1011; col=0111 → fil=1111.
  - Cycles 9–12: fil=1111 for any col.
  - Cycle 13: done=1, busy=0.
- Byte 0x45, P=8, R=4:
  - key_active=4 in cycles 1–12 and 5 in cycles 13–24.
  - Key 4 (row 1, col 0): col=0111 → fil=1011.
  - done pulses in cycle 25.
- Key D (row 3, col 3): col=1110 → fil=1110; col=0000 → fil=1110; col=1101 → fil=1111.
- Bounce, key 1, BOUNCE_CYCLES=32, BOUNCE_TOGGLE=8, P=64, col held 0111:
  - fil[3] low in cycles 1–8, high 9–16, low 17–24, high 25–32, low 33–64.
- Busy rejection: start with 0x12, then start with 0x99 in cycle 5 → no effect; the 1, 2 sequence completes unchanged and done pulses once.
